ram_req_ctrl: RTL and testbench
===============================

Name: ram_req_ctrl

Overview:
Request front-end that sits directly upstream of the 64K x 8 RAM and is the only block that drives its port. It accepts single or burst read and fill requests over a valid/ready handshake and sequences them onto the RAM's wren/addr/wdata lines. Read bytes are captured into a small response FIFO with backpressure. After reset it issues a one-cycle clear to the RAM.

Parameters:
ADDR_W, 16, RAM address width; addresses wrap modulo 2**ADDR_W
DATA_W, 8, RAM data width
LEN_W, 4, burst length field width; burst beats = req_len+1 (1..16)
RSP_DEPTH, 4, response FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  controller can accept a request
req_wr  in  1  1 = fill-write burst, 0 = read burst
req_addr  in  ADDR_W  burst start address
req_wdata  in  DATA_W  fill byte, written to every beat of a write burst
req_len  in  LEN_W  beats minus one
rsp_valid  out  1  read response present (FIFO head)
rsp_ready  in  1  consumer takes response
rsp_rdata  out  DATA_W  read byte
rsp_last  out  1  head entry is the final beat of its burst
mem_clr  out  1  to RAM rst (active-high clear)
mem_wren  out  1  to RAM wren
mem_addr  out  ADDR_W  to RAM addr
mem_wdata  out  DATA_W  to RAM wdata
mem_rdata  in  DATA_W  from RAM rdata (combinational w.r.t. mem_addr)

Behaviour:
- All outputs are registered except rsp_* (FIFO head) and req_ready (decoded from state).
- Reset (rst==0 at an edge): state=INIT; FIFO flushed; rd_cap=0. Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_last=0, mem_clr=0, mem_wren=0, mem_addr=0, mem_wdata=0. Applies mid-burst; the burst is abandoned with no partial responses.
- FSM: INIT -> IDLE -> {WR, RD} -> IDLE.
- INIT: on the first edge with rst==1, mem_clr=1 for exactly one cycle. req_ready=0. Next state is IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready: latch addr, len, and wdata into a beat counter. Go to WR if req_wr else RD. req_ready=0 in all other states; an offered request must be held until accepted.
- WR: each cycle drives mem_wren=1, mem_addr=cur, mem_wdata=fill.
  - First beat is driven at the acceptance edge.
  - cur increments by 1 per cycle with wrap (all-ones -> 0).
  - After the last beat's cycle, mem_wren=0 while mem_addr and mem_wdata hold their last values for that edge, so no stray write occurs.
  - Then go to IDLE. A write burst produces no response.
- RD: mem_wren=0 throughout.
  - A beat is issued by loading mem_addr=cur and setting rd_cap=1, with the last flag tagged.
  - At the next edge, {mem_rdata, last} is pushed into the FIFO and rd_cap clears unless another beat is issued.
  - Issue is allowed only when fifo_count + rd_cap < RSP_DEPTH. Otherwise mem_addr holds and no beat is issued.
  - Beats issue back-to-back when space allows.
  - Go to IDLE at the edge that issues the last beat. The final capture completes one edge later, independent of state; a following request may start at that same edge.
- Latency: a read accepted at edge E0 has its first rsp_valid after E1, i.e. 2 cycles. With rsp_ready=1 continuously, beats follow on consecutive cycles.
- FIFO:
  - Pop on rsp_valid&&rsp_ready.
  - Simultaneous push and pop when full or empty is legal and the count is unchanged.
  - Never overflows, because issue is gated.
  - Responses are returned strictly in address order.
- Only one burst is in flight; reads and writes never overlap on the RAM port.

Test Plan:
1. rst=0 for 3 cycles, then 1 -> mem_clr=1 for exactly the first cycle, req_ready=1 from the next cycle; all outputs 0 during reset.
2. Write addr 0x1234, wdata 0xA5, len 0; then read 0x1234, len 0 -> mem_wren high for 1 cycle at 0x1234; rsp_rdata=0xA5, rsp_last=1, rsp_valid 2 cycles after read acceptance.
3. Write addr 0xFFFE, len 3, wdata 0x5A -> writes hit 0xFFFE, 0xFFFF, 0x0000, 0x0001. Read the same range -> four 0x5A responses, rsp_last only on the 4th.
4. Read len 15 with rsp_ready=0 -> exactly 4 addresses issued, then mem_addr stalls. Raise rsp_ready -> all 16 bytes delivered in order, rsp_last on the 16th, no loss or duplication.
5. rst=0 during beat 5 of a 16-beat read -> rsp_valid=0 and mem_wren=0 after that edge, FIFO empty. On release, a new mem_clr pulse occurs, then IDLE.
6. req_valid held high with a second request during an active burst -> req_ready stays 0. The request is accepted on the first IDLE cycle and its fields are used unchanged.

Source files
------------

// File: rtl/ram_req_ctrl_if.sv
// rtl/ram_req_ctrl_if.sv - request/response handshake and RAM port bundle for ram_req_ctrl
// master = requester plus RAM side, slave = the controller.
interface ram_req_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LEN_W-1:0]  req_len;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_last;
  logic              mem_clr;
  logic              mem_wren;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, req_len, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last, mem_clr, mem_wren, mem_addr, mem_wdata
  );

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, req_len, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_last, mem_clr, mem_wren, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ram_req_ctrl.sv
// rtl/ram_req_ctrl.sv - burst read/fill sequencer in front of the 64K x 8 RAM
// Reads land in a small response FIFO; beat issue is throttled so it never overflows.
module ram_req_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int LEN_W     = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  ram_req_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WR, S_RD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cur;
  logic [LEN_W-1:0]  cnt;
  logic              rd_cap;
  logic              rd_last;
  logic              clr_q;
  logic              wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W:0]   fifo_q [RSP_DEPTH];
  logic [PTR_W-1:0]  wp;
  logic [PTR_W-1:0]  rp;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    occ;
  logic              space;
  logic              push;
  logic              pop;
  logic              accept;

  // An in-flight capture already owns a FIFO slot.
  assign occ    = {1'b0, count} + {{CNT_W{1'b0}}, rd_cap};
  assign space  = occ < (CNT_W+1)'(RSP_DEPTH);
  assign push   = rd_cap;
  assign pop    = bus.rsp_valid && bus.rsp_ready;

  assign bus.rsp_valid = (count != '0);
  assign bus.rsp_rdata = bus.rsp_valid ? fifo_q[rp][DATA_W-1:0] : '0;
  assign bus.rsp_last  = bus.rsp_valid && fifo_q[rp][DATA_W];

  // Hold off requests while the RAM clear is on the wire.
  assign bus.req_ready = (state == S_IDLE) && !clr_q;
  assign accept        = bus.req_valid && bus.req_ready;

  assign bus.mem_clr   = clr_q;
  assign bus.mem_wren  = wren_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_INIT;
      cur     <= '0;
      cnt     <= '0;
      rd_cap  <= 1'b0;
      rd_last <= 1'b0;
      clr_q   <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
    end else begin
      clr_q  <= 1'b0;
      rd_cap <= 1'b0;

      if (push) begin
        fifo_q[wp] <= {rd_last, bus.mem_rdata};
        wp         <= wp + PTR_W'(1);
      end
      if (pop) rp <= rp + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase

      case (state)
        S_INIT: begin
          clr_q <= 1'b1;
          state <= S_IDLE;
        end
        S_IDLE: begin
          if (accept) begin
            if (bus.req_wr) begin
              wren_q  <= 1'b1;
              addr_q  <= bus.req_addr;
              wdata_q <= bus.req_wdata;
              cur     <= bus.req_addr + ADDR_W'(1);
              cnt     <= bus.req_len;
              state   <= S_WR;
            end else if (space) begin
              addr_q  <= bus.req_addr;
              rd_cap  <= 1'b1;
              rd_last <= (bus.req_len == '0);
              cur     <= bus.req_addr + ADDR_W'(1);
              cnt     <= bus.req_len - LEN_W'(1);
              state   <= (bus.req_len == '0) ? S_IDLE : S_RD;
            end else begin
              cur   <= bus.req_addr;
              cnt   <= bus.req_len;
              state <= S_RD;
            end
          end
        end
        S_WR: begin
          // Address and data hold on the closing edge so the RAM sees no stray write.
          if (cnt == '0) begin
            wren_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            addr_q <= cur;
            cur    <= cur + ADDR_W'(1);
            cnt    <= cnt - LEN_W'(1);
          end
        end
        S_RD: begin
          if (space) begin
            addr_q  <= cur;
            rd_cap  <= 1'b1;
            rd_last <= (cnt == '0);
            cur     <= cur + ADDR_W'(1);
            cnt     <= cnt - LEN_W'(1);
            if (cnt == '0) state <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_req_ctrl.sv
// tb/tb_ram_req_ctrl.sv - scoreboard bench for ram_req_ctrl with a behavioural 64K x 8 RAM
module tb_ram_req_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [7:0]  ram    [0:65535];
  logic [7:0]  shadow [0:65535];
  logic [8:0]  exp_q  [$];
  logic [23:0] exp_wr [$];

  ram_req_ctrl_if #(.ADDR_W(16), .DATA_W(8), .LEN_W(4)) bus ();

  ram_req_ctrl #(.ADDR_W(16), .DATA_W(8), .LEN_W(4), .RSP_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = ram[bus.mem_addr];

  always @(posedge clk) begin
    if (bus.mem_clr === 1'b1) begin
      for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
    end else if (bus.mem_wren === 1'b1) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  always @(negedge clk) begin
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) fail("rsp_unexpected");
      else chk("rsp", {55'd0, bus.rsp_last, bus.rsp_rdata}, {55'd0, exp_q.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (bus.mem_wren === 1'b1) begin
      if (exp_wr.size() == 0) fail("wr_stray");
      else chk("wr", {40'd0, bus.mem_addr, bus.mem_wdata}, {40'd0, exp_wr.pop_front()});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic wr, input logic [15:0] a, input logic [7:0] d,
                          input logic [3:0] l);
    bit ok;
    ok = 1'b0;
    bus.req_wr    = wr;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_len   = l;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) begin
        step();
        ok = 1'b1;
      end
    end
    bus.req_valid = 1'b0;
    if (!ok) fail("req_timeout");
  endtask

  task automatic expect_write(input logic [15:0] a, input logic [7:0] d, input logic [3:0] l);
    logic [15:0] ad;
    for (int i = 0; i <= int'(l); i++) begin
      ad = a + 16'(i);
      shadow[ad] = d;
      exp_wr.push_back({ad, d});
    end
  endtask

  task automatic expect_read(input logic [15:0] a, input logic [3:0] l);
    logic [15:0] ad;
    for (int i = 0; i <= int'(l); i++) begin
      ad = a + 16'(i);
      exp_q.push_back({(i == int'(l)), shadow[ad]});
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (exp_q.size() != 0 || exp_wr.size() != 0); i++) step();
    chk("drain", 64'(exp_q.size() + exp_wr.size()), 64'd0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      chk("rst_outs", {27'd0, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_last,
                       bus.mem_clr, bus.mem_wren, bus.mem_addr, bus.mem_wdata}, 64'd0);
    end
    exp_q.delete();
    exp_wr.delete();
    foreach (shadow[i]) shadow[i] = 8'h00;
    rst = 1'b1;
    step();
    chk("clr_pulse", {62'd0, bus.mem_clr, bus.req_ready}, 64'd2);
    step();
    chk("clr_done", {62'd0, bus.mem_clr, bus.req_ready}, 64'd1);
  endtask

  initial begin
    int busy;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_len   = '0;
    bus.rsp_ready = 1'b1;
    foreach (ram[i]) ram[i] = 8'h00;

    do_reset(3);

    // single write then single read, with latency check
    expect_write(16'h1234, 8'hA5, 4'd0);
    send_req(1'b1, 16'h1234, 8'hA5, 4'd0);
    drain();
    expect_read(16'h1234, 4'd0);
    send_req(1'b0, 16'h1234, 8'h00, 4'd0);
    @(negedge clk);
    chk("lat_e0", {63'd0, bus.rsp_valid}, 64'd0);
    @(negedge clk);
    chk("lat_e1", {63'd0, bus.rsp_valid}, 64'd1);
    drain();

    // wrapping burst write and read-back
    expect_write(16'hFFFE, 8'h5A, 4'd3);
    send_req(1'b1, 16'hFFFE, 8'h5A, 4'd3);
    drain();
    expect_read(16'hFFFE, 4'd3);
    send_req(1'b0, 16'hFFFE, 8'h00, 4'd3);
    drain();

    // 16-beat read under backpressure
    expect_write(16'hFFF8, 8'h11, 4'd1);
    send_req(1'b1, 16'hFFF8, 8'h11, 4'd1);
    expect_write(16'h0004, 8'h33, 4'd2);
    send_req(1'b1, 16'h0004, 8'h33, 4'd2);
    drain();
    bus.rsp_ready = 1'b0;
    expect_read(16'hFFF8, 4'd15);
    send_req(1'b0, 16'hFFF8, 8'h00, 4'd15);
    repeat (10) @(negedge clk);
    chk("stall_addr", {48'd0, bus.mem_addr}, 64'hFFFB);
    chk("stall_head", {55'd0, bus.rsp_valid, bus.rsp_rdata}, 64'h111);
    repeat (3) @(negedge clk);
    chk("stall_hold", {48'd0, bus.mem_addr}, 64'hFFFB);
    step();
    bus.rsp_ready = 1'b1;
    drain();

    // reset in the middle of a 16-beat read
    expect_read(16'h0000, 4'd15);
    send_req(1'b0, 16'h0000, 8'h00, 4'd15);
    repeat (4) step();
    do_reset(1);

    // second request held during an active write burst
    expect_write(16'h2000, 8'h77, 4'd7);
    send_req(1'b1, 16'h2000, 8'h77, 4'd7);
    expect_read(16'h2000, 4'd1);
    bus.req_wr    = 1'b0;
    bus.req_addr  = 16'h2000;
    bus.req_wdata = 8'hEE;
    bus.req_len   = 4'd1;
    bus.req_valid = 1'b1;
    busy = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready === 1'b1) break;
      busy++;
    end
    chk("busy_cycles", 64'(busy), 64'd8);
    step();
    bus.req_valid = 1'b0;
    drain();

    repeat (5) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
